// File: rtl/uart_tx_framer.sv
// UART transmitter: small byte FIFO, 16x baud tick divider and an 8E1 frame serialiser.
// Define TX_TWO_STOP_BITS_EN to send two stop bits per frame (8E2).
module uart_tx_framer #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] Tx_DATA,
    input  logic       Tx_WR,
    input  logic       Tx_EN,
    input  logic [2:0] baud_select,
    output logic       TxD,
    output logic       Tx_BUSY,
    output logic       Tx_FULL,
    output logic       Tx_OVF
);

    function automatic int div_for(input int baud);
        return (CLK_HZ + 8 * baud) / (16 * baud);
    endfunction

    localparam int DIV_300    = div_for(300);
    localparam int DIV_1200   = div_for(1200);
    localparam int DIV_4800   = div_for(4800);
    localparam int DIV_9600   = div_for(9600);
    localparam int DIV_19200  = div_for(19200);
    localparam int DIV_38400  = div_for(38400);
    localparam int DIV_57600  = div_for(57600);
    localparam int DIV_115200 = div_for(115200);
    localparam int DIV_W      = $clog2(DIV_300 + 1);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t             state;
    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [7:0]         shreg;
    logic               parity;
    logic [2:0]         bit_cnt;
    logic [DIV_W-1:0]   div_cnt, divisor;
    logic [3:0]         tick_cnt;
    logic [2:0]         baud_reg;
    logic               busy, ovf;
    logic               tick, bit_end, frame_end, can_start, pop, wr_accept, last_stop;

`ifdef TX_TWO_STOP_BITS_EN
    logic               stop_second;
    assign last_stop = stop_second;
`else
    assign last_stop = 1'b1;
`endif

    always_comb begin
        divisor = DIV_W'(DIV_115200);
        case (baud_reg)
            3'b000: divisor = DIV_W'(DIV_300);
            3'b001: divisor = DIV_W'(DIV_1200);
            3'b010: divisor = DIV_W'(DIV_4800);
            3'b011: divisor = DIV_W'(DIV_9600);
            3'b100: divisor = DIV_W'(DIV_19200);
            3'b101: divisor = DIV_W'(DIV_38400);
            3'b110: divisor = DIV_W'(DIV_57600);
            3'b111: divisor = DIV_W'(DIV_115200);
        endcase
    end

    assign Tx_FULL   = (count == CNT_W'(FIFO_DEPTH));
    assign Tx_BUSY   = busy;
    assign Tx_OVF    = ovf;
    assign wr_accept = Tx_WR && !Tx_FULL;
    assign can_start = Tx_EN && (count != '0);
    assign tick      = (state != IDLE) && (div_cnt == divisor - DIV_W'(1));
    assign bit_end   = tick && (tick_cnt == 4'd15);
    assign frame_end = (state == STOP) && bit_end && last_stop;
    assign pop       = ((state == IDLE) || frame_end) && can_start;

    always_ff @(posedge clk) begin
        if (wr_accept)
            fifo_mem[wr_ptr] <= Tx_DATA;
    end

    // A write is judged against the registered full flag, so a simultaneous pop cannot rescue it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            ovf <= Tx_WR && Tx_FULL;
            if (wr_accept)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Divider and frame sequencer share one block so a frame start also restarts bit timing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            TxD      <= 1'b1;
            busy     <= 1'b0;
            shreg    <= '0;
            parity   <= 1'b0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            tick_cnt <= '0;
            baud_reg <= '0;
`ifdef TX_TWO_STOP_BITS_EN
            stop_second <= 1'b0;
`endif
        end else begin
            if (state == IDLE || pop) begin
                div_cnt  <= '0;
                tick_cnt <= '0;
            end else if (tick) begin
                div_cnt  <= '0;
                tick_cnt <= tick_cnt + 4'd1;
            end else begin
                div_cnt  <= div_cnt + DIV_W'(1);
            end

            if (pop) begin
                state    <= START;
                TxD      <= 1'b0;
                busy     <= 1'b1;
                shreg    <= fifo_mem[rd_ptr];
                parity   <= ^fifo_mem[rd_ptr];
                baud_reg <= baud_select;
                bit_cnt  <= '0;
`ifdef TX_TWO_STOP_BITS_EN
                stop_second <= 1'b0;
`endif
            end else if (bit_end) begin
                case (state)
                    START: begin
                        state <= DATA;
                        TxD   <= shreg[0];
                    end
                    DATA: begin
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                            TxD   <= parity;
                        end else begin
                            TxD     <= shreg[1];
                            shreg   <= {1'b0, shreg[7:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    PARITY: begin
                        state <= STOP;
                        TxD   <= 1'b1;
                    end
                    STOP: begin
`ifdef TX_TWO_STOP_BITS_EN
                        if (!stop_second) begin
                            stop_second <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
`else
                        state <= IDLE;
                        busy  <= 1'b0;
`endif
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        TxD   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed self-checking bench for uart_tx_framer at 50 MHz (115200 baud = 432 clocks per bit).
module tb_uart_tx_framer;

    localparam int B = 432;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] Tx_DATA;
    logic       Tx_WR, Tx_EN;
    logic [2:0] baud_select;
    logic       TxD, Tx_BUSY, Tx_FULL, Tx_OVF;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_framer #(.CLK_HZ(50_000_000), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .Tx_DATA(Tx_DATA), .Tx_WR(Tx_WR), .Tx_EN(Tx_EN),
        .baud_select(baud_select), .TxD(TxD), .Tx_BUSY(Tx_BUSY), .Tx_FULL(Tx_FULL), .Tx_OVF(Tx_OVF)
    );

    // Expected 8E1 frame, index 0 = start bit, 10 = stop bit.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        return {1'b1, ^d, d, 1'b0};
    endfunction

    task automatic write_byte(input logic [7:0] d);
        @(negedge clk); Tx_DATA = d; Tx_WR = 1'b1;
        @(negedge clk); Tx_WR = 1'b0;
    endtask

    task automatic wait_fall(input int limit, output bit ok);
        int n = 0;
        while (TxD !== 1'b0 && n < limit) begin @(negedge clk); n++; end
        ok = (TxD === 1'b0);
    endtask

    task automatic measure_run(input logic level, input int limit, output int n);
        n = 0;
        while (TxD === level && n < limit) begin n++; @(negedge clk); end
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (Tx_BUSY !== 1'b0 && n < limit) begin @(negedge clk); n++; end
    endtask

    // Called on the first negedge of a start bit; samples each bit at its centre.
    task automatic sample_frame(input int b, input int drop_en_at, input int baud_at, output logic [10:0] bits);
        repeat (b / 2) @(negedge clk);
        bits[0] = TxD;
        for (int i = 1; i < 11; i++) begin
            repeat (b) @(negedge clk);
            bits[i] = TxD;
            if (drop_en_at == i) Tx_EN = 1'b0;
            if (baud_at == i) baud_select = 3'b011;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; Tx_DATA = '0; Tx_WR = 1'b0; Tx_EN = 1'b0; baud_select = 3'b111;
        repeat (3) @(negedge clk);
        total++; if (TxD !== 1'b1)     begin bad++; $display("[TB] FAIL reset_txd: got %b want 1", TxD); end
        total++; if (Tx_BUSY !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", Tx_BUSY); end
        total++; if (Tx_FULL !== 1'b0) begin bad++; $display("[TB] FAIL reset_full: got %b want 0", Tx_FULL); end
        total++; if (Tx_OVF !== 1'b0)  begin bad++; $display("[TB] FAIL reset_ovf: got %b want 0", Tx_OVF); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (TxD !== 1'b1)     begin bad++; $display("[TB] FAIL idle_txd: got %b want 1", TxD); end
    endtask

    task automatic test_single_frame;
        int exp_runs [9] = '{1, 1, 1, 1, 2, 1, 1, 1, 1};
        logic level;
        int n, t0;
        Tx_EN = 1'b1; baud_select = 3'b111;
        write_byte(8'hA5);
        total++; if (TxD !== 1'b1) begin bad++; $display("[TB] FAIL a5_prefall: got %b want 1", TxD); end
        @(negedge clk);
        total++; if (TxD !== 1'b0)     begin bad++; $display("[TB] FAIL a5_fall: got %b want 0", TxD); end
        total++; if (Tx_BUSY !== 1'b1) begin bad++; $display("[TB] FAIL a5_busy: got %b want 1", Tx_BUSY); end
        t0 = cyc;
        level = 1'b0;
        for (int i = 0; i < 9; i++) begin
            measure_run(level, exp_runs[i] * B + 100, n);
            total++;
            if (n !== exp_runs[i] * B) begin bad++; $display("[TB] FAIL a5_run%0d: got %0d clks want %0d", i, n, exp_runs[i] * B); end
            level = ~level;
        end
        wait_idle(B + 100);
        total++; if (cyc - t0 !== 11 * B) begin bad++; $display("[TB] FAIL a5_busy_len: got %0d want %0d", cyc - t0, 11 * B); end
        total++; if (TxD !== 1'b1) begin bad++; $display("[TB] FAIL a5_idle_txd: got %b want 1", TxD); end
    endtask

    task automatic test_parity_loopback;
        logic [10:0] bits;
        bit ok;
        write_byte(8'h07);
        wait_fall(10, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL p07_start: got no start bit want start"); end
        sample_frame(B, -1, -1, bits);
        total++; if (bits[8:1] !== 8'h07) begin bad++; $display("[TB] FAIL p07_data: got %h want 07", bits[8:1]); end
        total++; if (bits[9] !== 1'b1)    begin bad++; $display("[TB] FAIL p07_parity: got %b want 1", bits[9]); end
        total++; if ((^bits[9:1]) !== 1'b0) begin bad++; $display("[TB] FAIL p07_perror: got 1 want 0"); end
        total++; if (bits[10] !== 1'b1)   begin bad++; $display("[TB] FAIL p07_ferror: got stop %b want 1", bits[10]); end
        wait_idle(B + 100);
        total++; if (Tx_BUSY !== 1'b0) begin bad++; $display("[TB] FAIL p07_idle: got %b want 0", Tx_BUSY); end
    endtask

    task automatic test_fifo_overflow;
        logic [7:0]  d [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        logic [10:0] bits;
        Tx_EN = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            Tx_DATA = d[i]; Tx_WR = 1'b1;
            @(negedge clk);
            if (i == 2) begin
                total++; if (Tx_FULL !== 1'b0) begin bad++; $display("[TB] FAIL full_after3: got %b want 0", Tx_FULL); end
            end
            if (i == 3) begin
                total++; if (Tx_FULL !== 1'b1) begin bad++; $display("[TB] FAIL full_after4: got %b want 1", Tx_FULL); end
                total++; if (Tx_OVF !== 1'b0)  begin bad++; $display("[TB] FAIL ovf_after4: got %b want 0", Tx_OVF); end
            end
            if (i == 4) begin
                total++; if (Tx_OVF !== 1'b1)  begin bad++; $display("[TB] FAIL ovf_after5: got %b want 1", Tx_OVF); end
            end
        end
        Tx_WR = 1'b0;
        @(negedge clk);
        total++; if (Tx_OVF !== 1'b0) begin bad++; $display("[TB] FAIL ovf_pulse_end: got %b want 0", Tx_OVF); end
        total++; if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) begin bad++; $display("[TB] FAIL disabled_idle: got txd=%b busy=%b want 1/0", TxD, Tx_BUSY); end
        Tx_EN = 1'b1;
        @(negedge clk);
        total++; if (TxD !== 1'b0)     begin bad++; $display("[TB] FAIL b2b_first_start: got %b want 0", TxD); end
        total++; if (Tx_FULL !== 1'b0) begin bad++; $display("[TB] FAIL full_after_pop: got %b want 0", Tx_FULL); end
        for (int f = 0; f < 4; f++) begin
            sample_frame(B, -1, -1, bits);
            total++;
            if (bits !== frame_of(d[f])) begin bad++; $display("[TB] FAIL b2b_frame%0d: got %b want %b", f, bits, frame_of(d[f])); end
            if (f < 3) begin
                repeat (B / 2 - 1) @(negedge clk);
                total++; if (TxD !== 1'b1) begin bad++; $display("[TB] FAIL b2b_stop%0d: got %b want 1", f, TxD); end
                @(negedge clk);
                total++; if (TxD !== 1'b0) begin bad++; $display("[TB] FAIL b2b_next%0d: got %b want 0", f, TxD); end
            end else begin
                repeat (B / 2) @(negedge clk);
                total++; if (Tx_BUSY !== 1'b0) begin bad++; $display("[TB] FAIL b2b_end_busy: got %b want 0", Tx_BUSY); end
            end
        end
        repeat (B) @(negedge clk);
        total++; if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) begin bad++; $display("[TB] FAIL dropped_not_sent: got txd=%b busy=%b want 1/0", TxD, Tx_BUSY); end
    endtask

    task automatic test_reset_midframe;
        logic [10:0] bits, exp;
        bit ok, stayed;
        Tx_EN = 1'b1;
        write_byte(8'h3C);
        wait_fall(10, ok);
        write_byte(8'h77);
        write_byte(8'hE1);
        repeat (3 * B + B / 2 - 4) @(negedge clk);
        exp = frame_of(8'h3C);
        total++; if (TxD !== exp[3])   begin bad++; $display("[TB] FAIL rst_bit3: got %b want %b", TxD, exp[3]); end
        total++; if (Tx_BUSY !== 1'b1) begin bad++; $display("[TB] FAIL rst_prebusy: got %b want 1", Tx_BUSY); end
        #2 reset = 1'b1;
        #1;
        total++; if (TxD !== 1'b1)     begin bad++; $display("[TB] FAIL rst_async_txd: got %b want 1", TxD); end
        total++; if (Tx_BUSY !== 1'b0) begin bad++; $display("[TB] FAIL rst_async_busy: got %b want 0", Tx_BUSY); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        stayed = 1'b1;
        repeat (20) begin @(negedge clk); if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) stayed = 1'b0; end
        total++; if (!stayed) begin bad++; $display("[TB] FAIL rst_fifo_empty: got activity want idle"); end
        write_byte(8'h96);
        wait_fall(4, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL rst_restart: got no start want start"); end
        sample_frame(B, -1, -1, bits);
        total++; if (bits !== frame_of(8'h96)) begin bad++; $display("[TB] FAIL rst_frame: got %b want %b", bits, frame_of(8'h96)); end
        wait_idle(B + 100);
    endtask

    task automatic test_enable_drop;
        logic [10:0] bits;
        Tx_EN = 1'b0;
        write_byte(8'h5A);
        write_byte(8'hC3);
        write_byte(8'h81);
        Tx_EN = 1'b1;
        @(negedge clk);
        sample_frame(B, 3, -1, bits);
        total++; if (bits !== frame_of(8'h5A)) begin bad++; $display("[TB] FAIL en_frame: got %b want %b", bits, frame_of(8'h5A)); end
        repeat (B / 2) @(negedge clk);
        total++; if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) begin bad++; $display("[TB] FAIL en_stopped: got txd=%b busy=%b want 1/0", TxD, Tx_BUSY); end
        repeat (2 * B) @(negedge clk);
        total++; if (TxD !== 1'b1) begin bad++; $display("[TB] FAIL en_held_high: got %b want 1", TxD); end
        Tx_EN = 1'b1;
        @(negedge clk);
        total++; if (TxD !== 1'b0) begin bad++; $display("[TB] FAIL en_resume: got %b want 0", TxD); end
        sample_frame(B, -1, -1, bits);
        total++; if (bits !== frame_of(8'hC3)) begin bad++; $display("[TB] FAIL en_frame2: got %b want %b", bits, frame_of(8'hC3)); end
        repeat (B / 2) @(negedge clk);
        total++; if (TxD !== 1'b0) begin bad++; $display("[TB] FAIL en_b2b3: got %b want 0", TxD); end
        sample_frame(B, -1, -1, bits);
        total++; if (bits !== frame_of(8'h81)) begin bad++; $display("[TB] FAIL en_frame3: got %b want %b", bits, frame_of(8'h81)); end
        wait_idle(B + 100);
    endtask

    task automatic test_baud_change;
        logic [10:0] bits;
        int n;
        Tx_EN = 1'b0; baud_select = 3'b111;
        write_byte(8'h55);
        write_byte(8'h0F);
        Tx_EN = 1'b1;
        @(negedge clk);
        sample_frame(B, -1, 2, bits);
        total++; if (bits !== frame_of(8'h55)) begin bad++; $display("[TB] FAIL baud_frame: got %b want %b", bits, frame_of(8'h55)); end
        repeat (B / 2 - 1) @(negedge clk);
        total++; if (TxD !== 1'b1) begin bad++; $display("[TB] FAIL baud_stop_len: got %b want 1", TxD); end
        @(negedge clk);
        total++; if (TxD !== 1'b0) begin bad++; $display("[TB] FAIL baud_next_start: got %b want 0", TxD); end
        measure_run(1'b0, 5216 + 200, n);
        total++; if (n !== 5216) begin bad++; $display("[TB] FAIL baud_9600_bit: got %0d clks want 5216", n); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0; baud_select = 3'b111;
        @(negedge clk);
        total++; if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) begin bad++; $display("[TB] FAIL final_idle: got txd=%b busy=%b want 1/0", TxD, Tx_BUSY); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_parity_loopback();
        test_fifo_overflow();
        test_reset_midframe();
        test_enable_drop();
        test_baud_change();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
UART transmit stage that produces the serial stream consumed by the team's UARTreceiver.
- Buffers bytes from the host side in a small FIFO.
- Generates its own 16x baud tick from baud_select, using the same rate table as the receiver.
- Serialises each byte as start, 8 data bits LSB first, even parity, stop on TxD.
- Drives TxD directly into the receiver's RxD (loopback) or off-chip.

Parameters:
CLK_HZ, 50_000_000, system clock frequency in Hz.
FIFO_DEPTH, 4, transmit FIFO entries; power of 2, minimum 2.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
Tx_DATA  input  8  byte to enqueue.
Tx_WR  input  1  write strobe; one byte enqueued per cycle high.
Tx_EN  input  1  transmit enable; gates frame starts only.
baud_select  input  3  rate: 000=300, 001=1200, 010=4800, 011=9600, 100=19200, 101=38400, 110=57600, 111=115200.
TxD  output  1  serial line, registered, idles high.
Tx_BUSY  output  1  high while state != IDLE.
Tx_FULL  output  1  FIFO count == FIFO_DEPTH.
Tx_OVF  output  1  one-cycle pulse when a write is dropped.

Behaviour:
- Reset (async, active-high):
  - TxD=1, Tx_BUSY=0, Tx_FULL=0, Tx_OVF=0.
  - FIFO pointers and count cleared; divider and tick counter cleared; state=IDLE.
  - Reset mid-frame aborts the frame; TxD returns high immediately.
- Tick divider:
  - divisor = round(CLK_HZ/(16*baud)); for 115200 at 50 MHz this is 27.
  - Emits a one-clk tick every divisor clocks.
  - Held cleared in IDLE; starts counting from 0 on the cycle the frame starts.
- Bit timing:
  - A 4-bit tick counter advances on each tick.
  - Every frame bit lasts exactly 16 ticks; state/bit advances on the tick that wraps the counter 15->0.
- FIFO write:
  - Tx_WR=1 with Tx_FULL=0 stores Tx_DATA; count updates at that edge.
  - Tx_WR=1 with Tx_FULL=1: byte dropped, Tx_OVF=1 for the next cycle.
  - A same-cycle pop does not rescue a write that sees Tx_FULL=1.
- FIFO pointers: wrap modulo FIFO_DEPTH. Count is the sole full/empty source.
- State machine (states IDLE, START, DATA, PARITY, STOP):
  - IDLE -> START when Tx_EN=1 and count>0.
    - Pops the head into the shift register and latches parity = XOR of the byte.
    - TxD=0 from that edge, so TxD falls 1 clk after the write edge into an empty, enabled FIFO.
  - START -> DATA after 16 ticks. TxD=data bit0.
  - DATA holds 8 bits, LSB first, 16 ticks each, using a 3-bit bit counter; -> PARITY after bit7.
  - PARITY drives the parity bit for 16 ticks -> STOP.
  - STOP drives 1 for 16 ticks. At the end:
    - Tx_EN=1 and count>0: pop and go directly to START (back-to-back, no idle bit).
    - Otherwise go to IDLE.
- Tx_EN=0 mid-frame: current frame completes; no further starts.
- baud_select:
  - Sampled into a register at each frame start.
  - Changes mid-frame have no effect until the next frame.
- Frame length: 11 bits = 176 ticks.

Optional Feature:
TX_TWO_STOP_BITS_EN
- Defined: STOP lasts 32 ticks (two stop bits), frame length 12 bits; the back-to-back decision is taken at the end of the second stop bit.
- Undefined: single stop bit exactly as above.

Test Plan:
1. CLK_HZ=50e6, baud_select=111, Tx_EN=1, write 0xA5 -> TxD falls 1 clk later; sequence 0,1,0,1,0,0,1,0,1,0(parity),1, each bit 432 clks; Tx_BUSY high for 4752 clks.
2. Write 0x07 -> parity bit 1. Loopback into UARTreceiver at the same baud_select -> Rx_VALID=1, Rx_DATA=0x07, Rx_PERROR=0, Rx_FERROR=0.
3. Tx_EN=0, write 0x11,0x22,0x33,0x44,0x55 on consecutive cycles:
   - Tx_FULL=1 after 4th write; 5th write gives a Tx_OVF pulse.
   - Then Tx_EN=1: 4 frames back-to-back, each stop bit followed immediately by a start bit; order 0x11..0x44; Tx_FULL drops after the first pop.
4. Assert reset at bit 3 of a frame -> TxD=1 and Tx_BUSY=0 within the reset cycle; FIFO empty; subsequent write transmits normally.
5. Deassert Tx_EN during DATA with 2 bytes queued -> current frame completes with correct stop bit; TxD stays high; re-enable resumes with the next byte.
6. Change baud_select 111->011 mid-frame -> current frame keeps 432-clk bits; next frame uses 5216-clk bits (divisor 326).
